// File: rtl/cmm_result_serializer.sv
// Captures one 4x4 complex result matrix in a single handshake and replays it
// word-by-word on an AXI-Stream master, with optional shift and upper-triangle reduction.
module cmm_result_serializer #(
  parameter int HERMITIAN_ONLY = 0,
  parameter int OUT_SHIFT      = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic          s_axis_dout_tvalid,
  output logic          s_axis_dout_tready,
  input  logic [1:0]    s_axis_dout_tuser,
  input  logic [1023:0] s_result_matrix,
  output logic [63:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic [5:0]    m_axis_tuser
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t        r_state, w_state_nxt;
  logic [1023:0] r_mat, w_mat_nxt;
  logic [1:0]    r_tag, w_tag_nxt;
  logic [1:0]    r_row, w_row_nxt;
  logic [1:0]    r_col, w_col_nxt;

  logic          w_cap;
  logic          w_beat;
  logic          w_last;
  logic [63:0]   w_elem;
  logic [31:0]   w_re;
  logic [31:0]   w_im;

  assign w_cap  = clken && (r_state == S_IDLE) && s_axis_dout_tvalid;
  assign w_beat = clken && (r_state == S_SEND) && m_axis_tready;
  assign w_last = (r_row == 2'd3) && (r_col == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mat   <= '0;
      r_tag   <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mat   <= w_mat_nxt;
      r_tag   <= w_tag_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mat_nxt   = r_mat;
    w_tag_nxt   = r_tag;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          w_mat_nxt   = s_result_matrix;
          w_tag_nxt   = s_axis_dout_tuser;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_beat) begin
          if (w_last) begin
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else if (r_col == 2'd3) begin
            // Upper-triangle mode restarts each row on the diagonal.
            w_row_nxt = r_row + 2'd1;
            w_col_nxt = (HERMITIAN_ONLY != 0) ? (r_row + 2'd1) : 2'd0;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_elem = r_mat[{r_row, r_col, 6'd0} +: 64];
  assign w_re   = $signed(w_elem[31:0])  >>> OUT_SHIFT;
  assign w_im   = $signed(w_elem[63:32]) >>> OUT_SHIFT;

  assign s_axis_dout_tready = (r_state == S_IDLE);
  assign m_axis_tvalid      = (r_state == S_SEND);
  assign m_axis_tdata       = m_axis_tvalid ? {w_im, w_re} : '0;
  assign m_axis_tuser       = m_axis_tvalid ? {r_tag, r_row, r_col} : '0;
  assign m_axis_tlast       = m_axis_tvalid && w_last;

endmodule
